conv_encoder_tx: RTL



---
 rtl/conv_encoder_tx.sv | 118 +++++++++++
 1 files changed

// File: rtl/conv_encoder_tx.sv
// Rate-1/2, K=3 convolutional encoder with serial transmit.
// Frame is latched on start, encoded MSB-first, coded bits shifted out one per clock.
module conv_encoder_tx #(
    parameter int         N  = 8,
    parameter logic [2:0] G0 = 3'b111,
    parameter logic [2:0] G1 = 3'b101
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   raw_data,
    output logic           ready,
    output logic           data_out,
    output logic           valid_out,
    output logic [2*N-1:0] encoded_data,
    output logic           done
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  shreg;
    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          phase;
    logic          u;
    logic          u_next;
    logic          last_bit;

    function automatic logic parity(input logic [2:0] g, input logic [2:0] v);
        return ^(g & v);
    endfunction

    assign u        = shreg[N-1];
    assign u_next   = shreg[N-2];
    assign last_bit = phase && (cnt == '0);
    assign ready    = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SEND;
            SEND:    if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // data_out is registered one step ahead: each edge loads the bit for
    // the following cycle, and shifts the bit just shown into the codeword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg        <= '0;
            s1           <= 1'b0;
            s2           <= 1'b0;
            cnt          <= '0;
            phase        <= 1'b0;
            data_out     <= 1'b0;
            valid_out    <= 1'b0;
            done         <= 1'b0;
            encoded_data <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shreg        <= raw_data;
                        s1           <= 1'b0;
                        s2           <= 1'b0;
                        cnt          <= CW'(N - 1);
                        phase        <= 1'b0;
                        encoded_data <= '0;
                        data_out     <= parity(G0, {raw_data[N-1], 2'b00});
                        valid_out    <= 1'b1;
                    end
                end
                SEND: begin
                    encoded_data <= {encoded_data[2*N-2:0], data_out};
                    if (!phase) begin
                        phase    <= 1'b1;
                        data_out <= parity(G1, {u, s1, s2});
                    end else begin
                        phase <= 1'b0;
                        s1    <= u;
                        s2    <= s1;
                        shreg <= {shreg[N-2:0], 1'b0};
                        if (cnt == '0) begin
                            valid_out <= 1'b0;
                            data_out  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cnt      <= cnt - 1'b1;
                            data_out <= parity(G0, {u_next, u, s1});
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
